// File: rtl/ui_pkg.sv
// Shared encodings for the board user interface: FSM states, input indices
// and the default debounce window. The LED display imports the same package.
package ui_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    localparam logic [1:0] WAIT_LOAD = 2'b00;
    localparam logic [1:0] READY     = 2'b01;
    localparam logic [1:0] RUN       = 2'b10;
    localparam logic [1:0] HALTED    = 2'b11;

    typedef enum logic [1:0] {
        S_WAIT_LOAD = WAIT_LOAD,
        S_READY     = READY,
        S_RUN       = RUN,
        S_HALTED    = HALTED
    } ctrl_state_e;

    // Bit positions of the three debounced front-panel inputs.
    localparam int IN_START = 0;
    localparam int IN_STEP  = 1;
    localparam int IN_MODE  = 2;
    localparam int NUM_IN   = 3;

endpackage

// File: rtl/user_ctrl_input_if.sv
// CPU-side control bus: loader/CPU status in, CPU control strobes and debug state out.
interface user_ctrl_input_if;

    logic       i_instr_transmit_done;
    logic       i_halt;
    logic       o_start_cpu;
    logic       o_step_execution;
    logic       o_step_pulse;
    logic [1:0] o_ctrl_state;

    // master: the user-input controller; slave: the CPU / LED display side.
    modport master (
        input  i_instr_transmit_done,
        input  i_halt,
        output o_start_cpu,
        output o_step_execution,
        output o_step_pulse,
        output o_ctrl_state
    );

    modport slave (
        output i_instr_transmit_done,
        output i_halt,
        input  o_start_cpu,
        input  o_step_execution,
        input  o_step_pulse,
        input  o_ctrl_state
    );

endinterface

// File: rtl/user_ctrl_input_debounce.sv
// Synchronizer + counter debouncer: a new level is accepted only after
// DEBOUNCE_CYCLES consecutive disagreeing samples; o_rise is a registered 1-cycle strobe.
module btn_debounce
    import ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = stable_q & ~stable_dly_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q       <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            rise_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync_q       <= {sync_q[0], i_raw};
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            rise_q       <= rise_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_level = stable_q;
    assign o_rise  = rise_q;

endmodule

// File: rtl/user_ctrl_input.sv
// Front-panel controller: debounces START/STEP/mode inputs and sequences the
// CPU through wait-for-load, ready, run and halted.
module user_ctrl_input
    import ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_btn_start,
    input  logic               i_btn_step,
    input  logic               i_sw_step_mode,
    user_ctrl_input_if.master  cpu
);

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] level;
    logic [NUM_IN-1:0] rise;

    assign raw[IN_START] = i_btn_start;
    assign raw[IN_STEP]  = i_btn_step;
    assign raw[IN_MODE]  = i_sw_step_mode;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_debounce
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_raw   (raw[gi]),
                .o_level (level[gi]),
                .o_rise  (rise[gi])
            );
        end
    endgenerate

    // Button levels and the switch edge are not needed by the sequencer.
    logic unused_dbg;
    assign unused_dbg = ^{level[IN_START], level[IN_STEP], rise[IN_MODE]};

    ctrl_state_e state_q;
    logic        start_cpu_q;
    logic        step_exec_q;
    logic        step_pulse_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_WAIT_LOAD;
            start_cpu_q  <= 1'b0;
            step_exec_q  <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            case (state_q)
                S_WAIT_LOAD: begin
                    step_exec_q <= level[IN_MODE];
                    if (cpu.i_instr_transmit_done) begin
                        state_q <= S_READY;
                    end
                end
                S_READY: begin
                    // Mode previews live here; the value taken on the START edge is kept for the run.
                    step_exec_q <= level[IN_MODE];
                    if (rise[IN_START]) begin
                        state_q     <= S_RUN;
                        start_cpu_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    start_cpu_q <= 1'b1;
                    if (cpu.i_halt) begin
                        state_q <= S_HALTED;
                    end else if (step_exec_q && rise[IN_STEP]) begin
                        step_pulse_q <= 1'b1;
                    end
                end
                S_HALTED: begin
                    start_cpu_q <= 1'b1;
                end
                default: begin
                    state_q <= S_WAIT_LOAD;
                end
            endcase
        end
    end

    assign cpu.o_start_cpu      = start_cpu_q;
    assign cpu.o_step_execution = step_exec_q;
    assign cpu.o_step_pulse     = step_pulse_q;
    assign cpu.o_ctrl_state     = state_q;

endmodule
